// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage: widths, register addressing,
// and the ID/EX control payload.
package operand_fetch_pkg;

  localparam int unsigned OF_WORD_SIZE = 16;
  localparam int unsigned NUM_REGS     = 4;
  localparam int unsigned REG_AW       = $clog2(NUM_REGS);
  localparam int unsigned BUBBLE_W     = 16;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    logic      reg_write;
    logic      mem_read;
    reg_addr_t dest;
  } idex_ctrl_t;

  // A producer matches a source when it is enabled and targets that register.
  function automatic logic src_hit(input logic en, input reg_addr_t dest, input reg_addr_t src);
    return en && (dest == src);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Bypass select for one source operand: EX result, then MEM data, then WB data,
// then register file.
module fwd_mux
  import operand_fetch_pkg::*;
#(
  parameter int unsigned W = OF_WORD_SIZE
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [W-1:0]      i_rf_data,
  input  logic              i_ex_valid,
  input  logic              i_ex_reg_write,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_dest,
  input  logic [W-1:0]      i_ex_result,
  input  logic              i_mem_valid,
  input  logic              i_mem_reg_write,
  input  logic [REG_AW-1:0] i_mem_dest,
  input  logic [W-1:0]      i_mem_data,
  input  logic              i_wb_reg_write,
  input  logic [REG_AW-1:0] i_wb_dest,
  input  logic [W-1:0]      i_wb_data,
  output logic [W-1:0]      o_data_c
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  // A load in EX has no data yet, so it never bypasses from EX.
  assign w_ex_hit  = src_hit(i_ex_valid & i_ex_reg_write & ~i_ex_mem_read, i_ex_dest, i_src);
  assign w_mem_hit = src_hit(i_mem_valid & i_mem_reg_write, i_mem_dest, i_src);
  assign w_wb_hit  = src_hit(i_wb_reg_write, i_wb_dest, i_src);

  always_comb begin
    o_data_c = i_rf_data;
    if (w_ex_hit) begin
      o_data_c = i_ex_result;
    end else if (w_mem_hit) begin
      o_data_c = i_mem_data;
    end else if (w_wb_hit) begin
      o_data_c = i_wb_data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register-file read with EX/MEM/WB bypass, load-use
// bubble insertion and the ID/EX pipeline latch.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned WORD_SIZE = OF_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic                 id_use_rs,
  input  logic                 id_use_rt,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic [REG_AW-1:0]    id_rs,
  input  logic [REG_AW-1:0]    id_rt,
  input  logic [REG_AW-1:0]    id_rd,
  input  logic [WORD_SIZE-1:0] id_imm,
  input  logic [WORD_SIZE-1:0] id_pc,
  output logic                 id_ready,
  output logic [REG_AW-1:0]    rf_read_reg1,
  output logic [REG_AW-1:0]    rf_read_reg2,
  input  logic [WORD_SIZE-1:0] rf_read_data1,
  input  logic [WORD_SIZE-1:0] rf_read_data2,
  input  logic                 ex_valid,
  input  logic                 ex_reg_write,
  input  logic                 ex_mem_read,
  input  logic [REG_AW-1:0]    ex_dest,
  input  logic [WORD_SIZE-1:0] ex_result,
  input  logic                 mem_valid,
  input  logic                 mem_reg_write,
  input  logic [REG_AW-1:0]    mem_dest,
  input  logic [WORD_SIZE-1:0] mem_data,
  input  logic                 wb_reg_write,
  input  logic [REG_AW-1:0]    wb_dest,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 ex_stall,
  input  logic                 flush,
  output logic                 out_valid,
  output logic                 out_reg_write,
  output logic                 out_mem_read,
  output logic [REG_AW-1:0]    out_dest,
  output logic [WORD_SIZE-1:0] out_a,
  output logic [WORD_SIZE-1:0] out_b,
  output logic [WORD_SIZE-1:0] out_imm,
  output logic [WORD_SIZE-1:0] out_pc,
  output logic [BUBBLE_W-1:0]  bubble_count
);

  idex_ctrl_t            r_ctrl;
  logic [WORD_SIZE-1:0]  r_a;
  logic [WORD_SIZE-1:0]  r_b;
  logic [WORD_SIZE-1:0]  r_imm;
  logic [WORD_SIZE-1:0]  r_pc;
  logic [BUBBLE_W-1:0]   r_bubble;

  logic [WORD_SIZE-1:0]  w_opa;
  logic [WORD_SIZE-1:0]  w_opb;
  logic                  w_ex_load;
  logic                  w_load_use;

  assign rf_read_reg1 = id_rs;
  assign rf_read_reg2 = id_rt;

  fwd_mux #(.W(WORD_SIZE)) u_fwd_a (
    .i_src           (id_rs),
    .i_rf_data       (rf_read_data1),
    .i_ex_valid      (ex_valid),
    .i_ex_reg_write  (ex_reg_write),
    .i_ex_mem_read   (ex_mem_read),
    .i_ex_dest       (ex_dest),
    .i_ex_result     (ex_result),
    .i_mem_valid     (mem_valid),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_dest      (mem_dest),
    .i_mem_data      (mem_data),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_dest       (wb_dest),
    .i_wb_data       (wb_data),
    .o_data_c        (w_opa)
  );

  fwd_mux #(.W(WORD_SIZE)) u_fwd_b (
    .i_src           (id_rt),
    .i_rf_data       (rf_read_data2),
    .i_ex_valid      (ex_valid),
    .i_ex_reg_write  (ex_reg_write),
    .i_ex_mem_read   (ex_mem_read),
    .i_ex_dest       (ex_dest),
    .i_ex_result     (ex_result),
    .i_mem_valid     (mem_valid),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_dest      (mem_dest),
    .i_mem_data      (mem_data),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_dest       (wb_dest),
    .i_wb_data       (wb_data),
    .o_data_c        (w_opb)
  );

  // A load in EX whose result the decoding instruction needs forces one bubble.
  assign w_ex_load  = ex_valid & ex_mem_read & ex_reg_write;
  assign w_load_use = id_valid & w_ex_load &
                      ((id_use_rs & (ex_dest == id_rs)) | (id_use_rt & (ex_dest == id_rt)));

  // Flush overrides any stall so the front end can redirect immediately.
  assign id_ready = flush | (~ex_stall & ~w_load_use);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_pc     <= '0;
      r_bubble <= '0;
    end else if (flush) begin
      r_ctrl.valid     <= 1'b0;
      r_ctrl.reg_write <= 1'b0;
      r_ctrl.mem_read  <= 1'b0;
    end else if (ex_stall) begin
      r_ctrl <= r_ctrl;
    end else if (w_load_use) begin
      r_ctrl.valid     <= 1'b0;
      r_ctrl.reg_write <= 1'b0;
      r_ctrl.mem_read  <= 1'b0;
      if (r_bubble != {BUBBLE_W{1'b1}}) begin
        r_bubble <= r_bubble + BUBBLE_W'(1);
      end
    end else begin
      r_ctrl.valid     <= id_valid;
      r_ctrl.reg_write <= id_valid & id_reg_write;
      r_ctrl.mem_read  <= id_valid & id_mem_read;
      r_ctrl.dest      <= id_rd;
      r_a              <= w_opa;
      r_b              <= w_opb;
      r_imm            <= id_imm;
      r_pc             <= id_pc;
    end
  end

  assign out_valid     = r_ctrl.valid;
  assign out_reg_write = r_ctrl.reg_write;
  assign out_mem_read  = r_ctrl.mem_read;
  assign out_dest      = r_ctrl.dest;
  assign out_a         = r_a;
  assign out_b         = r_b;
  assign out_imm       = r_imm;
  assign out_pc        = r_pc;
  assign bubble_count  = r_bubble;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: stimulus queues the expected latch state
// per cycle, a monitor pops and compares after every rising edge.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic [1:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm, id_pc;
  logic        id_ready;
  logic [1:0]  rf_read_reg1, rf_read_reg2;
  logic [15:0] rf_read_data1, rf_read_data2;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [1:0]  ex_dest;
  logic [15:0] ex_result;
  logic        mem_valid, mem_reg_write;
  logic [1:0]  mem_dest;
  logic [15:0] mem_data;
  logic        wb_reg_write;
  logic [1:0]  wb_dest;
  logic [15:0] wb_data;
  logic        ex_stall, flush;
  logic        out_valid, out_reg_write, out_mem_read;
  logic [1:0]  out_dest;
  logic [15:0] out_a, out_b, out_imm, out_pc;
  logic [15:0] bubble_count;

  logic [15:0] rf [4];
  assign rf_read_data1 = rf[rf_read_reg1];
  assign rf_read_data2 = rf[rf_read_reg2];

  always #5 clk = ~clk;

  operand_fetch #(.WORD_SIZE(16)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .id_pc(id_pc),
    .id_ready(id_ready),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_dest(ex_dest), .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
    .mem_data(mem_data),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush),
    .out_valid(out_valid), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_dest(out_dest), .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
    .out_pc(out_pc), .bubble_count(bubble_count)
  );

  typedef struct {
    logic        m_ready, m_ctrl, m_data, m_bc;
    logic        ready, valid, rw, mr;
    logic [1:0]  dest;
    logic [15:0] a, b, imm, pc, bc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t full(input logic ready, input logic valid, input logic rw,
                                input logic mr, input logic [1:0] dest, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] imm,
                                input logic [15:0] pc, input logic [15:0] bc);
    exp_t e;
    e.m_ready = 1'b1; e.m_ctrl = 1'b1; e.m_data = 1'b1; e.m_bc = 1'b1;
    e.ready = ready; e.valid = valid; e.rw = rw; e.mr = mr; e.dest = dest;
    e.a = a; e.b = b; e.imm = imm; e.pc = pc; e.bc = bc;
    return e;
  endfunction

  function automatic exp_t none();
    exp_t e;
    e = full(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e.m_ready = 1'b0; e.m_ctrl = 1'b0; e.m_data = 1'b0; e.m_bc = 1'b0;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: id_ready sampled at the edge (inputs stable), latch #1 after.
  initial begin
    exp_t e;
    logic rdy;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        rdy = id_ready;
        #1;
        if (e.m_ready) cmp("id_ready", 16'(rdy), 16'(e.ready));
        if (e.m_ctrl) begin
          cmp("out_valid", 16'(out_valid), 16'(e.valid));
          cmp("out_reg_write", 16'(out_reg_write), 16'(e.rw));
          cmp("out_mem_read", 16'(out_mem_read), 16'(e.mr));
        end
        if (e.m_data) begin
          cmp("out_dest", 16'(out_dest), 16'(e.dest));
          cmp("out_a", out_a, e.a);
          cmp("out_b", out_b, e.b);
          cmp("out_imm", out_imm, e.imm);
          cmp("out_pc", out_pc, e.pc);
        end
        if (e.m_bc) cmp("bubble_count", bubble_count, e.bc);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic step(input exp_t e);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic clr();
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_reg_write = 0; id_mem_read = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_imm = 0; id_pc = 0;
    ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0; ex_dest = 0; ex_result = 0;
    mem_valid = 0; mem_reg_write = 0; mem_dest = 0; mem_data = 0;
    wb_reg_write = 0; wb_dest = 0; wb_data = 0; ex_stall = 0; flush = 0;
  endtask

  task automatic load_use_in();
    clr();
    id_valid = 1; id_use_rs = 1; id_rs = 3; id_reg_write = 1;
    ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_dest = 3;
  endtask

  initial begin
    exp_t e;
    rf[0] = 16'h00A0; rf[1] = 16'h0011; rf[2] = 16'h0022; rf[3] = 16'h0033;
    clr();
    reset = 1;
    @(negedge clk);
    e = full(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e.m_ready = 0;
    step(e);
    reset = 0;

    // Plain register-file read.
    id_valid = 1; id_use_rs = 1; id_rs = 1; id_rt = 0; id_reg_write = 1;
    id_imm = 16'h0005; id_pc = 16'h0010;
    step(full(1, 1, 1, 0, 0, 16'h0011, 16'h00A0, 16'h0005, 16'h0010, 0));

    // Bypass priority on rt=2: EX > MEM > WB > RF.
    id_use_rt = 1; id_rt = 2; id_rd = 1; id_pc = 16'h0012;
    ex_valid = 1; ex_reg_write = 1; ex_dest = 2; ex_result = 16'h1234;
    mem_valid = 1; mem_reg_write = 1; mem_dest = 2; mem_data = 16'h5678;
    wb_reg_write = 1; wb_dest = 2; wb_data = 16'h9ABC;
    step(full(1, 1, 1, 0, 1, 16'h0011, 16'h1234, 16'h0005, 16'h0012, 0));
    ex_valid = 0;
    step(full(1, 1, 1, 0, 1, 16'h0011, 16'h5678, 16'h0005, 16'h0012, 0));
    mem_valid = 0;
    step(full(1, 1, 1, 0, 1, 16'h0011, 16'h9ABC, 16'h0005, 16'h0012, 0));
    wb_reg_write = 0;
    step(full(1, 1, 1, 0, 1, 16'h0011, 16'h0022, 16'h0005, 16'h0012, 0));

    // r0 is forwarded like any other register.
    id_use_rs = 0; id_use_rt = 0; id_rs = 0;
    ex_valid = 1; ex_reg_write = 1; ex_dest = 0; ex_result = 16'hBEEF;
    step(full(1, 1, 1, 0, 1, 16'hBEEF, 16'h0022, 16'h0005, 16'h0012, 0));

    // EX load not forwarded; without use flags it is not a hazard either.
    id_rs = 2; ex_mem_read = 1; ex_dest = 2;
    mem_valid = 1; mem_reg_write = 1; mem_dest = 2; mem_data = 16'h5678;
    step(full(1, 1, 1, 0, 1, 16'h5678, 16'h5678, 16'h0005, 16'h0012, 0));

    // Load-use bubble, then MEM bypass of the loaded value.
    clr();
    id_valid = 1; id_use_rs = 1; id_rs = 3; id_rt = 1; id_reg_write = 1; id_rd = 2;
    id_imm = 16'h0007; id_pc = 16'h0020;
    ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_dest = 3;
    e = full(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); e.m_data = 0;
    step(e);
    ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0;
    mem_valid = 1; mem_reg_write = 1; mem_dest = 3; mem_data = 16'h00FF;
    step(full(1, 1, 1, 0, 2, 16'h00FF, 16'h0011, 16'h0007, 16'h0020, 1));

    // Stall holds the latch for three cycles, even over a load-use.
    clr();
    id_valid = 1; id_use_rs = 1; id_rs = 1; id_rt = 3; id_reg_write = 1; id_mem_read = 1;
    id_rd = 2; id_imm = 16'h0008; id_pc = 16'h0040;
    step(full(1, 1, 1, 1, 2, 16'h0011, 16'h0033, 16'h0008, 16'h0040, 1));
    ex_stall = 1; id_pc = 16'h0099; id_rs = 2; id_rd = 0;
    ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_dest = 2;
    for (int i = 0; i < 3; i++)
      step(full(0, 1, 1, 1, 2, 16'h0011, 16'h0033, 16'h0008, 16'h0040, 1));

    // Flush wins over stall and load-use.
    flush = 1;
    e = full(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); e.m_data = 0;
    step(e);

    // Invalid instruction: control flags forced low.
    clr();
    id_reg_write = 1; id_mem_read = 1;
    e = full(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); e.m_data = 0;
    step(e);

    // Reset during a stall discards the held instruction.
    id_valid = 1; id_use_rs = 1; id_rs = 1; id_rd = 1; id_pc = 16'h0050;
    id_reg_write = 1; id_mem_read = 0;
    step(full(1, 1, 1, 0, 1, 16'h0011, 16'h00A0, 16'h0000, 16'h0050, 1));
    ex_stall = 1; reset = 1;
    e = full(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e.m_ready = 0;
    step(e);
    ex_stall = 0; reset = 0; id_pc = 16'h0052;
    step(full(1, 1, 1, 0, 1, 16'h0011, 16'h00A0, 16'h0000, 16'h0052, 0));

    // Saturation of the bubble counter.
    load_use_in();
    for (int k = 1; k <= 32'h10000; k++) begin
      if (k == 1 || k == 32'hFFFE || k == 32'hFFFF || k == 32'h10000) begin
        e = full(0, 0, 0, 0, 0, 0, 0, 0, 0, (k > 32'hFFFF) ? 16'hFFFF : 16'(k));
        e.m_data = 0;
        step(e);
      end else begin
        step(none());
      end
    end
    reset = 1;
    e = full(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e.m_ready = 0;
    step(e);
    reset = 0;
    clr();
    step(none());

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
